// File: rtl/mem_ctrl_if.sv
// Cache-side request/response bus plus the memory control port of mem_ctrl.
// slave = the controller; master = the requester/memory side that drives the requests and the read data.
interface mem_ctrl_if;
    logic         clr_req;
    logic         clr_done;
    logic         wb_req;
    logic [5:0]   wb_addr;
    logic [127:0] wb_data;
    logic         wb_done;
    logic         rd_req;
    logic [5:0]   rd_addr;
    logic [127:0] rd_line;
    logic         rd_done;
    logic         busy;
    logic         mem_cs;
    logic         mem_rw;
    logic         mem_reset;
    logic [5:0]   mem_raddr;
    logic [5:0]   mem_waddr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;

    modport slave (
        input  clr_req, wb_req, wb_addr, wb_data, rd_req, rd_addr, mem_rdata,
        output clr_done, wb_done, rd_line, rd_done, busy,
               mem_cs, mem_rw, mem_reset, mem_raddr, mem_waddr, mem_wdata
    );

    modport master (
        output clr_req, wb_req, wb_addr, wb_data, rd_req, rd_addr, mem_rdata,
        input  clr_done, wb_done, rd_line, rd_done, busy,
               mem_cs, mem_rw, mem_reset, mem_raddr, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Line-level memory controller: clear (2 cycles), refill (2) and 4-beat write-back (5) to done.
// Requests are held by the requester until done; arbitration clr > wb > rd happens only in IDLE.
module mem_ctrl (
    input  logic       clk,
    input  logic       reset,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLR, RD, WR, DONE} state_t;
    typedef enum logic [1:0] {OP_CLR, OP_WB, OP_RD} op_t;

    state_t       state, state_nxt;
    op_t          op, op_nxt;
    logic [1:0]   beat;
    logic [5:0]   base;
    logic [127:0] line_dat;
    logic [127:0] rd_line_q;

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLR;
                    op_nxt    = OP_CLR;
                end else if (bus.wb_req) begin
                    state_nxt = WR;
                    op_nxt    = OP_WB;
                end else if (bus.rd_req) begin
                    state_nxt = RD;
                    op_nxt    = OP_RD;
                end
            end
            CLR:     state_nxt = DONE;
            RD:      state_nxt = DONE;
            WR:      if (beat == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_CLR;
            beat      <= 2'd0;
            base      <= 6'd0;
            line_dat  <= 128'd0;
            rd_line_q <= 128'd0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            if (state == IDLE) begin
                beat <= 2'd0;
                // Latch only for the request that actually wins this cycle.
                if (!bus.clr_req && bus.wb_req) begin
                    base     <= {bus.wb_addr[5:2], 2'b00};
                    line_dat <= bus.wb_data;
                end else if (!bus.clr_req && bus.rd_req) begin
                    base <= {bus.rd_addr[5:2], 2'b00};
                end
            end
            if (state == WR) beat <= beat + 2'd1;
            if (state == RD) rd_line_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        bus.mem_cs    = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_reset = 1'b0;
        bus.mem_raddr = 6'd0;
        bus.mem_waddr = 6'd0;
        bus.mem_wdata = 32'd0;
        bus.clr_done  = 1'b0;
        bus.wb_done   = 1'b0;
        bus.rd_done   = 1'b0;
        case (state)
            CLR: begin
                bus.mem_cs    = 1'b1;
                bus.mem_reset = 1'b1;
            end
            RD: begin
                bus.mem_cs    = 1'b1;
                bus.mem_raddr = base;
            end
            WR: begin
                bus.mem_cs    = 1'b1;
                bus.mem_rw    = 1'b1;
                bus.mem_waddr = base + {4'd0, beat};
                case (beat)
                    2'd0:    bus.mem_wdata = line_dat[127:96];
                    2'd1:    bus.mem_wdata = line_dat[95:64];
                    2'd2:    bus.mem_wdata = line_dat[63:32];
                    default: bus.mem_wdata = line_dat[31:0];
                endcase
            end
            DONE: begin
                bus.clr_done = (op == OP_CLR);
                bus.wb_done  = (op == OP_WB);
                bus.rd_done  = (op == OP_RD);
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.rd_line = rd_line_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected writes, read addresses and
// done events; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_mem_ctrl;
    localparam int K_CLR = 0;
    localparam int K_WB  = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] line;
    } done_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    logic preload;
    int   cyc;
    int   checks;
    int   errors;
    int   clr_cycles;

    logic [31:0] mem [64];

    done_t      exp_done [$];
    wr_t        exp_wr   [$];
    logic [5:0] exp_ra   [$];

    mem_ctrl_if ifc ();

    mem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: synchronous write / clear, combinational 4-word line read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
        end else if (ifc.mem_cs && ifc.mem_rw) begin
            mem[ifc.mem_waddr] <= ifc.mem_wdata;
        end else if (ifc.mem_cs && ifc.mem_reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end
    end

    always_comb begin
        ifc.mem_rdata = {mem[ifc.mem_raddr], mem[ifc.mem_raddr + 6'd1],
                         mem[ifc.mem_raddr + 6'd2], mem[ifc.mem_raddr + 6'd3]};
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every memory access and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.mem_cs && ifc.mem_rw) begin
                if (exp_wr.size() == 0) chk("unexpected_write", {ifc.mem_waddr, ifc.mem_wdata}, 128'd0);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("waddr", ifc.mem_waddr, w.addr);
                    chk("wdata", ifc.mem_wdata, w.data);
                end
            end
            if (ifc.mem_cs && !ifc.mem_rw && !ifc.mem_reset) begin
                if (exp_ra.size() == 0) chk("unexpected_read", ifc.mem_raddr, 6'h3f);
                else chk("raddr", ifc.mem_raddr, exp_ra.pop_front());
            end
            if (ifc.mem_cs && ifc.mem_reset) clr_cycles++;
            if (ifc.clr_done || ifc.wb_done || ifc.rd_done) begin
                chk("one_done", 32'(ifc.clr_done) + 32'(ifc.wb_done) + 32'(ifc.rd_done), 1);
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    done_t d;
                    int    k;
                    d = exp_done.pop_front();
                    k = ifc.clr_done ? K_CLR : (ifc.wb_done ? K_WB : K_RD);
                    chk("done_kind", k, d.kind);
                    chk("done_cycle", cyc, d.cyc);
                    if (k == K_RD) chk("rd_line", ifc.rd_line, d.line);
                end
            end
        end
    end

    // Waits for the given done pulse, drops its request, returns busy cycles seen on the way.
    task automatic wait_done(input int kind, output int busy_cnt);
        bit got;
        got      = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ifc.busy) busy_cnt++;
            if ((kind == K_CLR && ifc.clr_done) || (kind == K_WB && ifc.wb_done) ||
                (kind == K_RD && ifc.rd_done)) got = 1'b1;
        end
        if (!got) chk("done_timeout", kind, 99);
        case (kind)
            K_CLR:   ifc.clr_req = 1'b0;
            K_WB:    ifc.wb_req  = 1'b0;
            default: ifc.rd_req  = 1'b0;
        endcase
    endtask

    task automatic push_wb(input logic [5:0] base, input logic [127:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = base + 6'(k);
            w.data = d[127 - 32*k -: 32];
            exp_wr.push_back(w);
        end
    endtask

    task automatic push_done(input int kind, input int at, input logic [127:0] line);
        done_t d;
        d.kind = kind;
        d.cyc  = at;
        d.line = line;
        exp_done.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int bc;
        logic [127:0] d1, d2, d3, d4;
        d1 = 128'h11111111_22222222_33333333_44444444;
        d2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        d3 = 128'h0BADF00D_FEEDFACE_55555555_66666666;
        d4 = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
        checks = 0; errors = 0; clr_cycles = 0; cyc = 0;
        ifc.clr_req = 1'b0; ifc.wb_req = 1'b0; ifc.rd_req = 1'b0;
        ifc.wb_addr = '0; ifc.wb_data = '0; ifc.rd_addr = '0;
        reset = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_ctl", {ifc.mem_cs, ifc.mem_rw, ifc.mem_reset}, 0);
        chk("rst_done", {ifc.clr_done, ifc.wb_done, ifc.rd_done}, 0);
        chk("rst_line", ifc.rd_line, 0);
        chk("rst_addr", {ifc.mem_raddr, ifc.mem_waddr, ifc.mem_wdata}, 0);
        preload = 1'b0; reset = 1'b0;

        // Clear
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.clr_req = 1'b1;
        push_done(K_CLR, g + 1, '0);
        wait_done(K_CLR, bc);
        chk("clr_cycles", clr_cycles, 1);

        // Read after clear returns zeros
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.rd_addr = 6'h08; ifc.rd_req = 1'b1;
        exp_ra.push_back(6'h08);
        push_done(K_RD, g + 1, '0);
        wait_done(K_RD, bc);

        // Write-back to 0x06 (base 0x04)
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.wb_addr = 6'h06; ifc.wb_data = d1; ifc.wb_req = 1'b1;
        push_wb(6'h04, d1, 4);
        push_done(K_WB, g + 4, '0);
        wait_done(K_WB, bc);

        // Read 0x05 returns the written line; input changes after grant are ignored
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.rd_addr = 6'h05; ifc.rd_req = 1'b1;
        exp_ra.push_back(6'h04);
        push_done(K_RD, g + 1, d1);
        @(posedge clk); #1;
        ifc.rd_addr = 6'h30;
        wait_done(K_RD, bc);

        // Simultaneous write-back and read: write-back first, read granted after DONE+IDLE
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.wb_addr = 6'h11; ifc.wb_data = d2; ifc.wb_req = 1'b1;
        ifc.rd_addr = 6'h07; ifc.rd_req = 1'b1;
        push_wb(6'h10, d2, 4);
        push_done(K_WB, g + 4, '0);
        exp_ra.push_back(6'h04);
        push_done(K_RD, g + 7, d1);
        wait_done(K_WB, bc);
        wait_done(K_RD, bc);

        // Top line: no wrap, busy for 5 cycles
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.wb_addr = 6'h3E; ifc.wb_data = d4; ifc.wb_req = 1'b1;
        push_wb(6'h3C, d4, 4);
        push_done(K_WB, g + 4, '0);
        wait_done(K_WB, bc);
        chk("busy_cycles_wb", bc, 5);
        @(negedge clk);
        chk("no_wrap_word0", mem[0], 32'd0);

        // Reset during beat 2 of a write-back to 0x20
        @(posedge clk); #1;
        ifc.wb_addr = 6'h20; ifc.wb_data = d3; ifc.wb_req = 1'b1;
        push_wb(6'h20, d3, 2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; ifc.wb_req = 1'b0;
        #1;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_ctl", {ifc.mem_cs, ifc.mem_rw, ifc.mem_reset}, 0);
        chk("abort_line", ifc.rd_line, 0);
        chk("abort_wdata", {ifc.mem_waddr, ifc.mem_wdata}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_w0", mem[6'h20], d3[127:96]);
        chk("abort_w1", mem[6'h21], d3[95:64]);
        chk("abort_w2", mem[6'h22], 32'd0);
        chk("abort_w3", mem[6'h23], 32'd0);

        // Next request after the abort is served normally
        @(posedge clk); #1;
        g = cyc + 1;
        ifc.rd_addr = 6'h22; ifc.rd_req = 1'b1;
        exp_ra.push_back(6'h20);
        push_done(K_RD, g + 1, {d3[127:64], 64'd0});
        wait_done(K_RD, bc);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("left_writes", exp_wr.size(), 0);
        chk("left_dones", exp_done.size(), 0);
        chk("left_reads", exp_ra.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Line-level controller and arbiter in front of the 64×32-bit main memory (`Mem`). It accepts whole-line (4-word, 128-bit) refill reads and dirty-line write-backs from the cache, plus a memory-clear request. It serialises each line write into four single-word memory writes and drives the memory's chip-select, read/write and clear controls. It is the only block permitted to drive the memory's control and address ports.

## Interface
- No parameters; the geometry is fixed at 6-bit word address, 32-bit word, 4-word line.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- clr_req  in  1  request to zero the whole memory; held until clr_done
- clr_done  out  1  one-cycle pulse: clear complete
- wb_req  in  1  write-back request; held until wb_done
- wb_addr  in  6  line address; bits [1:0] ignored (treated as 0)
- wb_data  in  128  line data; bits [127:96] go to word 0 (base address)
- wb_done  out  1  one-cycle pulse: all 4 words written
- rd_req  in  1  refill request; held until rd_done
- rd_addr  in  6  line address; bits [1:0] ignored
- rd_line  out  128  registered line; valid from the rd_done cycle and held until the next read completes
- rd_done  out  1  one-cycle pulse: rd_line valid
- busy  out  1  high whenever the state is not IDLE
- mem_cs, mem_rw, mem_reset  out  1 each  memory chip-select, write enable, and clear
- mem_raddr, mem_waddr  out  6 each  memory addresses
- mem_wdata  out  32  memory write word
- mem_rdata  in  128  combinational memory read data

## Operation
- States:
  - IDLE: no memory access.
  - CLR: 1 cycle.
  - RD: 1 cycle.
  - WR: 4 cycles, tracked by 2-bit beat counter.
  - DONE: 1 cycle.
- Arbitration happens only in IDLE, with fixed priority clr_req > wb_req > rd_req. On grant, the request's address is latched with [1:0] forced to 00. For a write-back, wb_data is also latched. Later changes on the input ports have no effect until the next grant.
- Write-back before refill priority is deliberate: an evicted dirty line must reach memory before its replacement is fetched.
- CLR: mem_cs=1, mem_reset=1 for one cycle, then DONE with clr_done.
- RD:
  - mem_cs=1, mem_rw=0, mem_raddr = latched base.
  - rd_line <= mem_rdata at the end of the cycle.
  - Next state is DONE with rd_done.
- WR beat k (k = 0..3):
  - mem_cs=1, mem_rw=1, mem_waddr = base+k.
  - mem_wdata = latched data[127-32k -: 32].
  - After beat 3, next state is DONE with wb_done.
- DONE: asserts exactly one done pulse (the one matching the granted request) and accepts no request. Next state is IDLE.
- Outside CLR/RD/WR: mem_cs=0, mem_rw=0, mem_reset=0.
- Outside RD/WR: addresses and mem_wdata are 0.
- Requester rule: drop req on the clock edge at which done is sampled high. A req still high in IDLE after DONE is treated as a new request.
- Addresses never wrap: the base is 4-aligned, so base+3 ≤ 63.

## Timing
- Reset values: state=IDLE, beat=0, rd_line=0. All done pulses, busy and mem_* outputs are 0.
- Reset is asynchronous and may arrive mid-operation:
  - Takes effect immediately and aborts the operation.
  - No done pulse is issued.
  - A write-back may be left partially written; the requester re-issues it.
  - rd_line is cleared to 0.
- Latency, counting the grant edge (IDLE→x) as edge 0:
  - clr_done in the cycle after edge 1; request-to-done = 2 cycles.
  - rd_done in the cycle after edge 1; request-to-done = 2 cycles.
  - wb_done in the cycle after edge 4; request-to-done = 5 cycles.
- Minimum spacing between back-to-back grants: read 3 cycles, write-back 6 cycles, clear 3 cycles (the IDLE cycle is included).
- Simultaneous requests: the lower-priority request stays pending and is granted in the first IDLE cycle after DONE.

## Test plan
- Reset, then clr_req → mem_cs=mem_reset=1 for exactly 1 cycle, clr_done 1 cycle later. A subsequent read of address 0x08 returns rd_line = 0.
- wb_req with wb_addr=0x06 and wb_data=0x11111111_22222222_33333333_44444444 → four writes: 0x04←0x11111111, 0x05←0x22222222, 0x06←0x33333333, 0x07←0x44444444. wb_done arrives 5 cycles after grant.
- Then rd_req with rd_addr=0x05 → mem_raddr=0x04 and rd_line equals that same 128-bit value. rd_done arrives 2 cycles after grant.
- wb_req and rd_req raised in the same cycle to different lines → write-back completes first (wb_done), then the read is granted. rd_done is 6 cycles after wb_done's grant + 2, with no cycle where both done pulses are high.
- Write-back to line 0x3C → writes 0x3C..0x3F with no wrap to 0x00. busy stays high for 5 cycles.
- Assert reset after WR beat 1 of a write-back → all outputs go to 0 at once, no wb_done. Words 0 and 1 are written; words 2 and 3 keep their old contents. The next request is served normally.
